// File: rtl/nibble_serial_adder.sv
// Wide adder that reuses one 4-bit carry-lookahead slice, one nibble per clock, LSB nibble first.
// Optional signed-overflow output is enabled by defining SERIAL_ADD_OVF_EN.
//
// state | meaning
// IDLE  | waiting for operands, in_ready high
// RUN   | adding one nibble per cycle through the lookahead slice
// DONE  | result held on sum/cout(/ovf) until out_ready

module nibble_serial_adder #(
  parameter int NIBBLES = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [4*NIBBLES-1:0]   a,
  input  logic [4*NIBBLES-1:0]   b,
  input  logic                   cin,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [4*NIBBLES-1:0]   sum,
  output logic                   cout
`ifdef SERIAL_ADD_OVF_EN
  ,
  output logic                   ovf
`endif
);

  localparam int W = 4 * NIBBLES;
  localparam logic [3:0] LAST_NIB = 4'(NIBBLES - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t        state_q;
  logic [W-1:0]  a_q;
  logic [W-1:0]  b_q;
  logic [W-1:0]  sum_q;
  logic          carry_q;
  logic [3:0]    cnt_q;
`ifdef SERIAL_ADD_OVF_EN
  logic          ovf_q;
`endif

  logic [3:0] g;
  logic [3:0] p;
  logic [3:0] c;
  logic [3:0] nib_sum;

  // Single lookahead slice: carry path is four bits deep regardless of NIBBLES.
  always_comb begin
    g    = a_q[3:0] & b_q[3:0];
    p    = a_q[3:0] ^ b_q[3:0];
    c[0] = g[0] | (p[0] & carry_q);
    c[1] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & carry_q);
    c[2] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & carry_q);
    c[3] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
         | ((&p) & carry_q);
    nib_sum = p ^ {c[2:0], carry_q};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
      carry_q <= 1'b0;
      cnt_q   <= '0;
`ifdef SERIAL_ADD_OVF_EN
      ovf_q   <= 1'b0;
`endif
    end else begin
      unique case (state_q)
        IDLE: begin
          if (in_valid) begin
            a_q     <= a;
            b_q     <= b;
            carry_q <= cin;
            cnt_q   <= '0;
`ifdef SERIAL_ADD_OVF_EN
            ovf_q   <= 1'b0;
`endif
            state_q <= RUN;
          end
        end
        RUN: begin
          sum_q   <= {nib_sum, sum_q[W-1:4]};
          a_q     <= {4'b0000, a_q[W-1:4]};
          b_q     <= {4'b0000, b_q[W-1:4]};
          carry_q <= c[3];
          cnt_q   <= cnt_q + 4'd1;
          if (cnt_q == LAST_NIB) begin
`ifdef SERIAL_ADD_OVF_EN
            ovf_q   <= c[2] ^ c[3];
`endif
            state_q <= DONE;
          end
        end
        DONE: begin
          if (out_ready) state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign sum       = sum_q;
  assign cout      = carry_q;
`ifdef SERIAL_ADD_OVF_EN
  assign ovf       = ovf_q;
`endif

endmodule

// File: tb/tb_nibble_serial_adder.sv
// Self-checking bench for nibble_serial_adder: directed cases plus random operands against an
// arithmetic reference; ovf is checked when SERIAL_ADD_OVF_EN is defined.

module tb_nibble_serial_adder;

  localparam int NIBBLES = 4;
  localparam int W = 4 * NIBBLES;

  logic          clk;
  logic          rst_n;
  logic          in_valid;
  logic          in_ready;
  logic [W-1:0]  a;
  logic [W-1:0]  b;
  logic          cin;
  logic          out_valid;
  logic          out_ready;
  logic [W-1:0]  sum;
  logic          cout;
`ifdef SERIAL_ADD_OVF_EN
  logic          ovf;
`endif

  int checks;
  int errors;

  nibble_serial_adder #(.NIBBLES(NIBBLES)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .cin       (cin),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .cout      (cout)
`ifdef SERIAL_ADD_OVF_EN
    ,
    .ovf       (ovf)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, obs, expv);
    end
  endtask

  task automatic check_result(input logic [W:0] expv, input logic ovf_exp);
    chk("out_valid", 32'(out_valid), 32'd1);
    chk("sum", 32'(sum), 32'(expv[W-1:0]));
    chk("cout", 32'(cout), 32'(expv[W]));
`ifdef SERIAL_ADD_OVF_EN
    chk("ovf", 32'(ovf), 32'(ovf_exp));
`else
    if (ovf_exp === 1'bx) chk("ovf_model", 32'(ovf_exp), 32'd0);
`endif
  endtask

  // hold = number of DONE cycles with out_ready low (0 = ready already high on entry);
  // junk = drive new operands with in_valid during DONE, which must be ignored.
  task automatic op(input logic [W-1:0] av, input logic [W-1:0] bv, input logic ci,
                    input int hold, input bit junk);
    logic [W:0] expv;
    logic       ovf_exp;
    int waited;
    waited = 0;
    while (in_ready !== 1'b1 && waited < 50) begin
      @(posedge clk); #1;
      waited++;
    end
    chk("accept_ready", 32'(in_ready), 32'd1);
    expv    = {1'b0, av} + {1'b0, bv} + (W+1)'(ci);
    ovf_exp = (av[W-1] == bv[W-1]) && (expv[W-1] != av[W-1]);
    a = av; b = bv; cin = ci; in_valid = 1'b1;
    out_ready = (hold == 0);
    @(posedge clk); #1;
    in_valid = 1'b0;
    a = W'($urandom); b = W'($urandom); cin = 1'($urandom);
    chk("busy_in_ready", 32'(in_ready), 32'd0);
    chk("early_valid", 32'(out_valid), 32'd0);
    for (int i = 1; i < NIBBLES; i++) begin
      @(posedge clk); #1;
      chk("early_valid", 32'(out_valid), 32'd0);
    end
    @(posedge clk); #1;
    check_result(expv, ovf_exp);
    chk("done_in_ready", 32'(in_ready), 32'd0);
    if (hold > 0) begin
      for (int k = 1; k < hold; k++) begin
        if (junk) begin
          in_valid = 1'b1; a = W'($urandom); b = W'($urandom); cin = 1'($urandom);
        end
        @(posedge clk); #1;
        check_result(expv, ovf_exp);
        chk("hold_in_ready", 32'(in_ready), 32'd0);
      end
      out_ready = 1'b1;
      @(posedge clk); #1;
    end else begin
      @(posedge clk); #1;
    end
    in_valid  = 1'b0;
    out_ready = 1'b0;
    chk("consumed_valid", 32'(out_valid), 32'd0);
    chk("idle_in_ready", 32'(in_ready), 32'd1);
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst_n = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    a = '0; b = '0; cin = 1'b0;
    #2 rst_n = 1'b0;
    #5;
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_sum", 32'(sum), 32'd0);
    chk("rst_cout", 32'(cout), 32'd0);
`ifdef SERIAL_ADD_OVF_EN
    chk("rst_ovf", 32'(ovf), 32'd0);
`endif
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk); #1;

    // Directed cases
    op(16'h1234, 16'h4321, 1'b0, 0, 1'b0);
    op(16'hFFFF, 16'h0001, 1'b0, 0, 1'b0);
    op(16'h00FF, 16'h0000, 1'b1, 0, 1'b0);
    op(16'hA5A5, 16'h5A5A, 1'b1, 3, 1'b1);
    op(16'h7FFF, 16'h0001, 1'b0, 1, 1'b0);
    op(16'h8000, 16'h8000, 1'b0, 2, 1'b0);

    // Reset during the second RUN cycle discards the partial result
    a = 16'hBEEF; b = 16'h1111; cin = 1'b1; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    chk("midrst_in_ready", 32'(in_ready), 32'd1);
    chk("midrst_out_valid", 32'(out_valid), 32'd0);
    chk("midrst_sum", 32'(sum), 32'd0);
    chk("midrst_cout", 32'(cout), 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    for (int i = 0; i < NIBBLES + 2; i++) begin
      @(posedge clk); #1;
      chk("midrst_no_result", 32'(out_valid), 32'd0);
    end
    op(16'h0001, 16'h0001, 1'b0, 0, 1'b0);

    // Random operands, carry-in and backpressure
    for (int n = 0; n < 24; n++) begin
      op(W'($urandom), W'($urandom), 1'($urandom), int'($urandom_range(0, 3)),
         1'($urandom));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
